// File: rtl/burst_shot.sv
// rtl/burst_shot.sv - edge-triggered burst pulse generator with delay, repeat, abort and retrigger
// Config is shadowed at acceptance; only a_idle stays live for the whole burst.
module burst_shot #(
    parameter int P_N_WIDTH  = 32,
    parameter int P_IO_WIDTH = 1,
    parameter int P_R_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trig,
    input  logic                  abort,
    input  logic                  retrig_en,
    input  logic [P_N_WIDTH-1:0]  n_dly,
    input  logic [P_N_WIDTH-1:0]  n_hi,
    input  logic [P_N_WIDTH-1:0]  n_lo,
    input  logic [P_R_WIDTH-1:0]  n_rep,
    input  logic [P_IO_WIDTH-1:0] a_idle,
    input  logic [P_IO_WIDTH-1:0] a_act,
    output logic                  busy,
    output logic                  done,
    output logic [P_R_WIDTH-1:0]  pulse_cnt,
    output logic [P_IO_WIDTH-1:0] y
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_ACTIVE = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    localparam logic [P_N_WIDTH-1:0] N_ONE = P_N_WIDTH'(1);
    localparam logic [P_R_WIDTH-1:0] R_ONE = P_R_WIDTH'(1);

    state_t                  state_q, state_d;
    logic                    trig_q;
    logic [P_N_WIDTH-1:0]    cnt_q, cnt_d;
    logic [P_R_WIDTH-1:0]    pcnt_q, pcnt_d;
    logic                    done_q, done_d;
    logic [P_N_WIDTH-1:0]    dly_q, hi_q, lo_q;
    logic [P_R_WIDTH-1:0]    rep_q;
    logic [P_IO_WIDTH-1:0]   act_q;

    logic trig_pe;
    logic cfg_ok;
    logic accept;

    assign trig_pe = trig & ~trig_q;
    assign cfg_ok  = (n_hi != '0) && (n_rep != '0);
    // abort wins over any same-cycle acceptance, including the shadow load
    assign accept  = trig_pe && cfg_ok && !abort && ((state_q == S_IDLE) || retrig_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            trig_q  <= 1'b0;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            done_q  <= 1'b0;
            dly_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rep_q   <= '0;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            trig_q  <= trig;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            done_q  <= done_d;
            if (accept) begin
                dly_q <= n_dly;
                hi_q  <= n_hi;
                lo_q  <= n_lo;
                rep_q <= n_rep;
                act_q <= a_act;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            state_d = (n_dly != '0) ? S_DELAY : S_ACTIVE;
            cnt_d   = '0;
            pcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                end
                S_DELAY: begin
                    if (cnt_q == dly_q - N_ONE) begin
                        cnt_d   = '0;
                        state_d = S_ACTIVE;
                    end else begin
                        cnt_d = cnt_q + N_ONE;
                    end
                end
                S_ACTIVE: begin
                    if (cnt_q == hi_q - N_ONE) begin
                        cnt_d  = '0;
                        pcnt_d = pcnt_q + R_ONE;
                        if (pcnt_q + R_ONE == rep_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else if (lo_q == '0) begin
                            state_d = S_ACTIVE;
                        end else begin
                            state_d = S_GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + N_ONE;
                    end
                end
                S_GAP: begin
                    if (cnt_q == lo_q - N_ONE) begin
                        cnt_d   = '0;
                        state_d = S_ACTIVE;
                    end else begin
                        cnt_d = cnt_q + N_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        y         = (state_q == S_ACTIVE) ? act_q : a_idle;
        done      = done_q;
        pulse_cnt = pcnt_q;
    end

endmodule

// File: tb/tb_burst_shot.sv
// tb/tb_burst_shot.sv - directed self-checking bench for burst_shot
// Narrow counters let the all-ones pulse length be exercised quickly.
module tb_burst_shot;

    localparam int NW = 4;
    localparam int IW = 2;
    localparam int RW = 8;
    localparam logic [IW-1:0] A_IDLE = 2'b01;
    localparam logic [IW-1:0] A_ACT  = 2'b10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          trig, abort, retrig_en;
    logic [NW-1:0] n_dly, n_hi, n_lo;
    logic [RW-1:0] n_rep;
    logic [IW-1:0] a_idle, a_act;
    logic          busy, done;
    logic [RW-1:0] pulse_cnt;
    logic [IW-1:0] y;

    int checks   = 0;
    int failures = 0;

    burst_shot #(.P_N_WIDTH(NW), .P_IO_WIDTH(IW), .P_R_WIDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n), .trig(trig), .abort(abort), .retrig_en(retrig_en),
        .n_dly(n_dly), .n_hi(n_hi), .n_lo(n_lo), .n_rep(n_rep),
        .a_idle(a_idle), .a_act(a_act),
        .busy(busy), .done(done), .pulse_cnt(pulse_cnt), .y(y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic config_set(input logic [NW-1:0] d, input logic [NW-1:0] h,
                              input logic [NW-1:0] l, input logic [RW-1:0] r);
        n_dly = d;
        n_hi  = h;
        n_lo  = l;
        n_rep = r;
        a_act = A_ACT;
    endtask

    // bit i of each mask / nibble i of pc_nib describes cycle i+1 after the accepting edge
    task automatic run_pattern(input string tag, input int n, input logic [31:0] act_m,
                               input logic [31:0] busy_m, input logic [31:0] done_m,
                               input logic [63:0] pc_nib);
        trig = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            if (i == 0) begin
                trig  = 1'b0;
                n_dly = 4'd3;
                n_hi  = 4'd7;
                n_lo  = 4'd5;
                n_rep = 8'd9;
                a_act = 2'b11;
            end
            check($sformatf("%s_y%0d", tag, i + 1), 32'(y), 32'(act_m[i] ? A_ACT : A_IDLE));
            check($sformatf("%s_busy%0d", tag, i + 1), 32'(busy), 32'(busy_m[i]));
            check($sformatf("%s_done%0d", tag, i + 1), 32'(done), 32'(done_m[i]));
            check($sformatf("%s_pc%0d", tag, i + 1), 32'(pulse_cnt), 32'(pc_nib[i*4 +: 4]));
        end
    endtask

    initial begin
        int busy_n;
        int done_n;
        int found;

        rst_n = 1'b0; trig = 1'b0; abort = 1'b0; retrig_en = 1'b0;
        a_idle = A_IDLE;
        config_set(4'd0, 4'd0, 4'd0, 8'd0);
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_y", 32'(y), 32'(A_IDLE));
        check("rst_done", 32'(done), 32'd0);
        check("rst_pc", 32'(pulse_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        config_set(4'd0, 4'd3, 4'd0, 8'd1);
        run_pattern("single", 4, 32'h7, 32'h7, 32'h8, 64'h1000);
        step();

        config_set(4'd0, 4'd0, 4'd0, 8'd1);
        trig = 1'b1;
        step();
        check("inv_hi_busy", 32'(busy), 32'd0);
        trig = 1'b0;
        step();
        check("inv_hi_done", 32'(done), 32'd0);
        check("inv_hi_pc", 32'(pulse_cnt), 32'd1);

        config_set(4'd0, 4'd3, 4'd0, 8'd0);
        trig = 1'b1;
        step();
        check("inv_rep_busy", 32'(busy), 32'd0);
        trig = 1'b0;
        step();
        check("inv_rep_done", 32'(done), 32'd0);
        check("inv_rep_pc", 32'(pulse_cnt), 32'd1);

        config_set(4'd2, 4'd2, 4'd1, 8'd3);
        run_pattern("dly", 11, 32'h36C, 32'h3FF, 32'h400, 64'h0000_0322_2111_0000);
        step();

        config_set(4'd0, 4'd2, 4'd0, 8'd2);
        run_pattern("b2b", 5, 32'hF, 32'hF, 32'h10, 64'h2_1100);
        step();

        config_set(4'd0, 4'hF, 4'd0, 8'd1);
        run_pattern("hi15", 16, 32'h7FFF, 32'h7FFF, 32'h8000, 64'h1000_0000_0000_0000);
        step();

        config_set(4'd0, 4'd1, 4'd0, 8'd1);
        busy_n = 0;
        done_n = 0;
        trig = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy) busy_n++;
            if (done) done_n++;
        end
        trig = 1'b0;
        step();
        check("held_busy_cycles", 32'(busy_n), 32'd1);
        check("held_done_count", 32'(done_n), 32'd1);

        config_set(4'd0, 4'd2, 4'd0, 8'd1);
        abort = 1'b1;
        trig  = 1'b1;
        step();
        check("abort_vs_trig_busy", 32'(busy), 32'd0);
        abort = 1'b0;
        step();
        check("abort_vs_trig_busy2", 32'(busy), 32'd0);
        trig = 1'b0;
        step();

        config_set(4'd0, 4'd2, 4'd1, 8'd4);
        trig = 1'b1;
        step();
        trig = 1'b0;
        step();
        step();
        check("abort_gap_y", 32'(y), 32'(A_IDLE));
        step();
        check("abort_p2_y", 32'(y), 32'(A_ACT));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_y", 32'(y), 32'(A_IDLE));
        check("abort_pc", 32'(pulse_cnt), 32'd1);
        done_n = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_n++;
            step();
        end
        check("abort_no_done", 32'(done_n), 32'd0);

        retrig_en = 1'b1;
        config_set(4'd2, 4'd2, 4'd3, 8'd2);
        trig = 1'b1;
        step();
        trig = 1'b0;
        step();
        step();
        check("retrig_p1_y", 32'(y), 32'(A_ACT));
        step();
        step();
        check("retrig_gap_pc", 32'(pulse_cnt), 32'd1);
        trig = 1'b1;
        step();
        trig = 1'b0;
        check("retrig_busy", 32'(busy), 32'd1);
        check("retrig_y", 32'(y), 32'(A_IDLE));
        check("retrig_pc", 32'(pulse_cnt), 32'd0);
        check("retrig_done", 32'(done), 32'd0);
        step();
        step();
        check("retrig_act_y", 32'(y), 32'(A_ACT));
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            step();
            if (done) found = i + 9;
        end
        check("retrig_done_cycle", 32'(found), 32'd15);
        check("retrig_final_pc", 32'(pulse_cnt), 32'd2);
        step();

        retrig_en = 1'b0;
        config_set(4'd2, 4'd2, 4'd3, 8'd2);
        trig = 1'b1;
        step();
        trig = 1'b0;
        step();
        step();
        step();
        step();
        trig = 1'b1;
        step();
        trig = 1'b0;
        check("noretrig_busy", 32'(busy), 32'd1);
        check("noretrig_pc", 32'(pulse_cnt), 32'd1);
        check("noretrig_y", 32'(y), 32'(A_IDLE));
        step();
        step();
        check("noretrig_act_y", 32'(y), 32'(A_ACT));
        step();
        step();
        check("noretrig_done", 32'(done), 32'd1);
        check("noretrig_pc_end", 32'(pulse_cnt), 32'd2);
        step();

        config_set(4'd0, 4'd5, 4'd0, 8'd1);
        trig = 1'b1;
        step();
        trig = 1'b0;
        step();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_y", 32'(y), 32'(A_IDLE));
        check("arst_done", 32'(done), 32'd0);
        check("arst_pc", 32'(pulse_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        config_set(4'd0, 4'd3, 4'd0, 8'd1);
        run_pattern("post_rst", 4, 32'h7, 32'h7, 32'h8, 64'h1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
